// File: rtl/ecg_frame_loader_if.sv
// ecg_frame_loader_if: sample stream, sample RAM write port and accelerator handshake
interface ecg_frame_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
);
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              ecg_rd_done;
   logic              acc_done;
   logic [4:0]        acc_classout;
   logic              class_valid;
   logic [4:0]        class_out;
   logic              timeout_err;
   logic [15:0]       frame_cnt;
   modport master (
      input  s_valid, s_data, acc_done, acc_classout,
      output s_ready, mem_we, mem_addr, mem_wdata, ecg_rd_done,
             class_valid, class_out, timeout_err, frame_cnt
   );
   modport slave (
      output s_valid, s_data, acc_done, acc_classout,
      input  s_ready, mem_we, mem_addr, mem_wdata, ecg_rd_done,
             class_valid, class_out, timeout_err, frame_cnt
   );
endinterface

// File: rtl/ecg_frame_loader.sv
// ecg_frame_loader: loads one ECG frame into sample RAM, starts inference, captures the class
module ecg_frame_loader #(
   parameter int DATA_W      = 16,
   parameter int NUM_SAMPLES = 1800,
   parameter int ADDR_W      = 11,
   parameter int TO_W        = 20,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ecg_frame_loader_if.master    bus
);
   typedef enum logic {LOAD, RUN} state_t;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [4:0]        class_out_q, class_out_d;
   logic              acc_done_q, s_ready_q, s_ready_d, rd_done_q, rd_done_d;
   logic              class_valid_q, class_valid_d, timeout_q, timeout_d;
   logic              we, done_edge;
   assign we              = bus.s_valid & s_ready_q;
   assign done_edge       = bus.acc_done & ~acc_done_q;
   assign bus.s_ready     = s_ready_q;
   assign bus.mem_we      = we;
   assign bus.mem_addr    = wr_addr_q;
   assign bus.mem_wdata   = bus.s_data;
   assign bus.ecg_rd_done = rd_done_q;
   assign bus.class_valid = class_valid_q;
   assign bus.class_out   = class_out_q;
   assign bus.timeout_err = timeout_q;
   assign bus.frame_cnt   = frame_cnt_q;
   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      to_cnt_d      = '0;
      frame_cnt_d   = frame_cnt_q;
      class_out_d   = class_out_q;
      s_ready_d     = s_ready_q;
      rd_done_d     = rd_done_q;
      class_valid_d = 1'b0;
      timeout_d     = 1'b0;
      case (state_q)
         LOAD: begin
            s_ready_d = 1'b1;
            if (we) begin
               wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
               if (wr_addr_q == LAST_ADDR) begin
                  s_ready_d = 1'b0;
                  rd_done_d = 1'b1;
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            s_ready_d = 1'b0;
            rd_done_d = 1'b1;
            to_cnt_d  = to_cnt_q + 1'b1;
            // a done edge landing on the last timeout cycle still counts as a result
            if (done_edge || to_cnt_q == TO_LAST) begin
               class_valid_d = done_edge;
               timeout_d     = ~done_edge;
               class_out_d   = done_edge ? bus.acc_classout : class_out_q;
               frame_cnt_d   = done_edge ? frame_cnt_q + 1'b1 : frame_cnt_q;
               rd_done_d     = 1'b0;
               to_cnt_d      = '0;
               s_ready_d     = 1'b1;
               state_d       = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= LOAD;
         wr_addr_q     <= '0;
         to_cnt_q      <= '0;
         frame_cnt_q   <= '0;
         class_out_q   <= '0;
         acc_done_q    <= 1'b0;
         s_ready_q     <= 1'b0;
         rd_done_q     <= 1'b0;
         class_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         to_cnt_q      <= to_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         class_out_q   <= class_out_d;
         acc_done_q    <= bus.acc_done;
         s_ready_q     <= s_ready_d;
         rd_done_q     <= rd_done_d;
         class_valid_q <= class_valid_d;
         timeout_q     <= timeout_d;
      end
   end
endmodule

// File: tb/tb_ecg_frame_loader.sv
// tb_ecg_frame_loader: frame table plus corner sequences, RAM writes checked via a scoreboard queue
module tb_ecg_frame_loader;
   localparam int NS = 8, TO = 64;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   ecg_frame_loader_if #(.DATA_W(16), .ADDR_W(11)) bus ();
   ecg_frame_loader #(.DATA_W(16), .NUM_SAMPLES(NS), .ADDR_W(11), .TO_W(20), .TIMEOUT_CYC(TO))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct packed { logic [10:0] a; logic [15:0] d; } wr_t;
   typedef struct { logic [15:0] base; bit gap; int delay; logic [4:0] cls; bit exp_cv; bit exp_to; } frame_t;
   wr_t exp_q[$];
   int checks = 0, fails = 0;
   logic [4:0]  exp_cls = '0;
   logic [15:0] exp_frames = '0;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.mem_we) begin
         if (exp_q.size() == 0) chk("unexpected_write", {5'd0, bus.mem_addr, bus.mem_wdata}, 32'hFFFFFFFF);
         else chk("ram_write", {5'd0, bus.mem_addr, bus.mem_wdata}, {5'd0, exp_q.pop_front()});
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic load_frame(input logic [15:0] base, input bit gap);
      int n = 0;
      for (int k = 0; k < 400 && n < NS; k++) begin
         bus.s_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.s_data  = base + 16'(n);
         if (bus.s_valid) begin
            exp_q.push_back({11'(n), base + 16'(n)});
            n++;
         end
         step();
      end
      bus.s_valid = 1'b0;
      chk("load_count", n, NS);
   endtask
   task automatic check_outcome(input string tag, input bit cv, input bit to);
      chk({tag, "_class_valid"}, bus.class_valid, cv);
      chk({tag, "_timeout_err"}, bus.timeout_err, to);
      chk({tag, "_class_out"}, bus.class_out, exp_cls);
      chk({tag, "_frame_cnt"}, bus.frame_cnt, exp_frames);
      chk({tag, "_rd_done_low"}, bus.ecg_rd_done, 0);
      chk({tag, "_s_ready_high"}, bus.s_ready, 1);
      bus.acc_done = 1'b0;
      step();
      chk({tag, "_pulse_end"}, {bus.class_valid, bus.timeout_err}, 0);
   endtask
   frame_t tbl [4];
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      tbl[0] = '{16'h0200, 1'b1, 5,   5'd7,  1'b1, 1'b0};
      tbl[1] = '{16'h0300, 1'b0, 100, 5'd9,  1'b0, 1'b1};
      tbl[2] = '{16'h0400, 1'b1, 63,  5'd21, 1'b1, 1'b0};
      tbl[3] = '{16'h0500, 1'b0, 0,   5'd31, 1'b1, 1'b0};
      bus.s_valid = 1'b0; bus.s_data = '0; bus.acc_done = 1'b0; bus.acc_classout = '0;
      #12;
      chk("rst_outputs", {bus.s_ready, bus.ecg_rd_done, bus.class_valid, bus.timeout_err, bus.mem_we}, 0);
      chk("rst_class_frame", {bus.class_out, bus.frame_cnt}, 0);
      #10 rst_n = 1'b1;
      step();
      chk("s_ready_rise", bus.s_ready, 1);
      // 1: back-to-back frame, then a 9th sample must not be taken
      load_frame(16'h0100, 1'b0);
      chk("t1_s_ready", bus.s_ready, 0);
      chk("t1_rd_done", bus.ecg_rd_done, 1);
      chk("t1_all_written", exp_q.size(), 0);
      bus.s_valid = 1'b1; bus.s_data = 16'h0108;
      chk("t1_no_9th", bus.mem_we, 0);
      step(); step();
      bus.s_valid = 1'b0;
      // 2: done pulse with class 3
      bus.acc_classout = 5'd3; bus.acc_done = 1'b1;
      step();
      exp_cls = 5'd3; exp_frames = 16'd1;
      check_outcome("t2", 1'b1, 1'b0);
      // 3/4: table of frames (gapped loads, timeout, coincident done/timeout, immediate done)
      foreach (tbl[i]) begin
         load_frame(tbl[i].base, tbl[i].gap);
         chk("run_rd_done", bus.ecg_rd_done, 1);
         chk("run_s_ready", bus.s_ready, 0);
         bus.acc_classout = tbl[i].cls;
         for (int c = 0; c < TO; c++) begin
            bus.acc_done = (c == tbl[i].delay);
            step();
            if (c == tbl[i].delay) break;
         end
         if (tbl[i].exp_cv) begin
            exp_cls = tbl[i].cls;
            exp_frames++;
         end
         check_outcome($sformatf("row%0d", i), tbl[i].exp_cv, tbl[i].exp_to);
      end
      // 5: done level held across RUN entry, re-raised on the timeout cycle
      begin
         int bad = 0;
         bus.acc_done = 1'b1; bus.acc_classout = 5'd12;
         load_frame(16'h0700, 1'b0);
         for (int c = 0; c < TO; c++) begin
            bus.acc_done = (c < 10) || (c == TO - 1);
            step();
            if (c < TO - 1 && (bus.class_valid || bus.timeout_err || !bus.ecg_rd_done)) bad++;
         end
         chk("t5_no_early_capture", bad, 0);
         exp_cls = 5'd12; exp_frames++;
         check_outcome("t5", 1'b1, 1'b0);
      end
      // 6: reset after four samples
      for (int i = 0; i < 4; i++) begin
         bus.s_valid = 1'b1; bus.s_data = 16'h0800 + 16'(i);
         exp_q.push_back({11'(i), 16'h0800 + 16'(i)});
         step();
      end
      bus.s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_outputs", {bus.s_ready, bus.ecg_rd_done, bus.class_valid, bus.timeout_err}, 0);
      chk("t6_rst_class_frame", {bus.class_out, bus.frame_cnt}, 0);
      chk("t6_partial_written", exp_q.size(), 0);
      exp_cls = '0; exp_frames = '0;
      #10 rst_n = 1'b1;
      step();
      chk("t6_s_ready", bus.s_ready, 1);
      load_frame(16'h0900, 1'b0);
      chk("t6_reload_rd_done", bus.ecg_rd_done, 1);
      @(negedge clk);
      chk("t6_all_written", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
